// File: rtl/aes_gcm_result_collector.sv
// Reorders tagged AES-GCM worker results by counter; emits one per cycle.
// Ports: 4-lane tagged input, valid/ready block stream out, sticky overflow.
// Optional: AES_GCM_COLLECT_OCCUPANCY_EN adds o_occupancy (valid-slot count).
module aes_gcm_result_collector #(
  parameter int CW    = 17,
  parameter int DEPTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic [0:LANES-1]       i_valid,
  input  logic [0:LANES*CW-1]    i_counter,
  input  logic [0:LANES*3-1]     i_phase,
  input  logic [0:LANES*128-1]   i_data,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [0:127]           o_data,
  output logic [0:CW-1]          o_counter,
  output logic [0:2]             o_phase,
  output logic                   o_last,
`ifdef AES_GCM_COLLECT_OCCUPANCY_EN
  output logic [0:$clog2(DEPTH)] o_occupancy,
`endif
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0] PH_INV   = 3'b100;
  localparam logic [2:0] PH_LAST  = 3'b011;
  localparam logic [2:0] PH_FLAST = 3'b111;

  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] slot_v_nxt;
  logic [127:0]     slot_dat [DEPTH];
  logic [CW-1:0]    slot_cnt [DEPTH];
  logic [2:0]       slot_ph  [DEPTH];
  logic [CW-1:0]    r_expect;

  logic [CW-1:0]    l_cnt  [LANES];
  logic [CW-1:0]    l_dist [LANES];
  logic [2:0]       l_ph   [LANES];
  logic [127:0]     l_dat  [LANES];
  logic [AW-1:0]    l_idx  [LANES];
  logic [LANES-1:0] l_act;
  logic [LANES-1:0] l_coll;
  logic [LANES-1:0] l_acc;
  logic [LANES-1:0] l_drop;

  logic [AW-1:0]    rd_idx;
  logic             can_adv;
  logic             pop;
  logic             pop_last;

  always_comb begin
    l_coll = '0;
    for (int k = 0; k < LANES; k++) begin
      l_cnt[k]  = i_counter[k*CW +: CW];
      l_ph[k]   = i_phase[k*3 +: 3];
      l_dat[k]  = i_data[k*128 +: 128];
      l_idx[k]  = l_cnt[k][AW-1:0];
      l_dist[k] = l_cnt[k] - r_expect;
      l_act[k]  = i_valid[k] && (l_ph[k] != PH_INV);
    end
    // Lanes aimed at the same slot cannot both be right: drop all of them.
    for (int j = 0; j < LANES; j++) begin
      for (int k = j + 1; k < LANES; k++) begin
        if (l_act[j] && l_act[k] && (l_idx[j] == l_idx[k])) begin
          l_coll[j] = 1'b1;
          l_coll[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < LANES; k++) begin
      l_acc[k]  = l_act[k] && !l_coll[k] &&
                  (l_dist[k] < DEPTH_C) && !slot_v[l_idx[k]];
      l_drop[k] = l_act[k] && !l_acc[k];
    end
  end

  assign rd_idx   = r_expect[AW-1:0];
  assign can_adv  = !o_valid || i_ready;
  assign pop      = can_adv && slot_v[rd_idx];
  assign pop_last = pop && ((slot_ph[rd_idx] == PH_LAST) ||
                            (slot_ph[rd_idx] == PH_FLAST));

  // Last-block pop flushes stale slots; same-edge writes land after it.
  always_comb begin
    slot_v_nxt = slot_v;
    if (pop_last)
      slot_v_nxt = '0;
    else if (pop)
      slot_v_nxt[rd_idx] = 1'b0;
    for (int k = 0; k < LANES; k++)
      if (l_acc[k])
        slot_v_nxt[l_idx[k]] = 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_v     <= '0;
      r_expect   <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_counter  <= '0;
      o_phase    <= PH_INV;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_dat[i] <= '0;
        slot_cnt[i] <= '0;
        slot_ph[i]  <= PH_INV;
      end
    end else begin
      slot_v <= slot_v_nxt;
      for (int k = 0; k < LANES; k++) begin
        if (l_acc[k]) begin
          slot_dat[l_idx[k]] <= l_dat[k];
          slot_cnt[l_idx[k]] <= l_cnt[k];
          slot_ph[l_idx[k]]  <= l_ph[k];
        end
      end
      if (|l_drop)
        o_overflow <= 1'b1;
      if (can_adv) begin
        o_valid <= pop;
        if (pop) begin
          o_data    <= slot_dat[rd_idx];
          o_counter <= slot_cnt[rd_idx];
          o_phase   <= slot_ph[rd_idx];
          o_last    <= pop_last;
          r_expect  <= pop_last ? '0 : r_expect + 1'b1;
        end
      end
    end
  end

`ifdef AES_GCM_COLLECT_OCCUPANCY_EN
  logic [AW:0] occ_nxt;

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      occ_nxt = occ_nxt + (AW+1)'(slot_v_nxt[i]);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_occupancy <= '0;
    else
      o_occupancy <= occ_nxt;
  end
`endif

endmodule

// File: tb/tb_aes_gcm_result_collector.sv
// Directed self-checking bench for aes_gcm_result_collector.
// Drives on the falling edge, checks just before driving.
module tb_aes_gcm_result_collector;

  localparam int CW = 17;

  logic           clk;
  logic           i_rst_n;
  logic [0:3]     i_valid;
  logic [0:4*CW-1] i_counter;
  logic [0:11]    i_phase;
  logic [0:511]   i_data;
  logic           i_ready;
  logic           o_valid;
  logic [0:127]   o_data;
  logic [0:CW-1]  o_counter;
  logic [0:2]     o_phase;
  logic           o_last;
  logic           o_overflow;
`ifdef AES_GCM_COLLECT_OCCUPANCY_EN
  logic [0:3]     o_occupancy;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  aes_gcm_result_collector dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_counter  (i_counter),
    .i_phase    (i_phase),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_counter  (o_counter),
    .o_phase    (o_phase),
    .o_last     (o_last),
`ifdef AES_GCM_COLLECT_OCCUPANCY_EN
    .o_occupancy(o_occupancy),
`endif
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic clear_lanes;
    i_valid = '0;
  endtask

  task automatic drive_lane(input int k, input logic [CW-1:0] c,
                            input logic [2:0] p, input logic [127:0] d);
    i_valid[k] = 1'b1;
    i_counter[k*CW +: CW] = c;
    i_phase[k*3 +: 3] = p;
    i_data[k*128 +: 128] = d;
  endtask

  task automatic pulse_reset;
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: valid=%b ovf=%b want 0 0", o_valid, o_overflow);
    end
    step;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== 128'h0 || o_counter !== 17'h0 ||
        o_phase !== 3'b100 || o_last !== 1'b0 || o_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: v=%b d=%h c=%h p=%b l=%b o=%b want 0 0 0 100 0 0",
               o_valid, o_data, o_counter, o_phase, o_last, o_overflow);
    end
`ifdef AES_GCM_COLLECT_OCCUPANCY_EN
    n_cmp++;
    if (o_occupancy !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_occ: got %0d want 0", o_occupancy);
    end
`endif
  endtask

  task automatic test_in_order;
    logic [2:0] ph;
    logic exp_v;
    for (int t = 0; t < 7; t++) begin
      clear_lanes;
      exp_v = (t >= 2 && t <= 5);
      n_cmp++;
      if (o_valid !== exp_v) begin
        n_bad++;
        $display("FAIL inorder_valid t=%0d: got %b want %b", t, o_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (o_counter !== 17'(t-2) || o_data !== 128'(32'h10 + t - 2) ||
            o_last !== (t == 5)) begin
          n_bad++;
          $display("FAIL inorder_data t=%0d: c=%h d=%h l=%b want c=%h l=%b",
                   t, o_counter, o_data, o_last, t-2, (t == 5));
        end
      end
      if (t < 4) begin
        case (t)
          0: ph = 3'b010;
          1: ph = 3'b000;
          2: ph = 3'b001;
          default: ph = 3'b011;
        endcase
        drive_lane(t, 17'(t), ph, 128'(32'h10 + t));
      end
      step;
    end
  endtask

  task automatic test_out_of_order;
    for (int t = 0; t < 6; t++) begin
      clear_lanes;
      if (t >= 2) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 128'(32'hA + t - 2) ||
            o_counter !== 17'(t-2) || o_last !== (t == 5)) begin
          n_bad++;
          $display("FAIL ooo t=%0d: v=%b d=%h c=%h l=%b want d=%h",
                   t, o_valid, o_data, o_counter, o_last, 32'hA + t - 2);
        end
      end
      if (t == 0) begin
        drive_lane(3, 17'd3, 3'b011, 128'hD);
        drive_lane(1, 17'd1, 3'b001, 128'hB);
        drive_lane(2, 17'd2, 3'b001, 128'hC);
        drive_lane(0, 17'd0, 3'b000, 128'hA);
      end
      step;
    end
    n_cmp++;
    if (o_overflow !== 1'b0 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ooo_end: ovf=%b v=%b want 0 0", o_overflow, o_valid);
    end
  endtask

  task automatic test_backpressure;
    int ec;
    i_ready = 1'b0;
    for (int t = 0; t < 13; t++) begin
      clear_lanes;
      ec = (t <= 6) ? 0 : t - 6;
      if (t >= 2 && t <= 11) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_counter !== 17'(ec) ||
            o_data !== 128'(32'h100 + ec) || o_last !== (ec == 5)) begin
          n_bad++;
          $display("FAIL bp t=%0d: v=%b c=%h d=%h l=%b want c=%h",
                   t, o_valid, o_counter, o_data, o_last, ec);
        end
      end
      if (t == 12) begin
        n_cmp++;
        if (o_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_end: v=%b want 0", o_valid);
        end
      end
      if (t == 0) begin
        drive_lane(0, 17'd0, 3'b000, 128'h100);
        drive_lane(1, 17'd1, 3'b001, 128'h101);
        drive_lane(2, 17'd2, 3'b001, 128'h102);
        drive_lane(3, 17'd3, 3'b001, 128'h103);
      end
      if (t == 1) begin
        drive_lane(0, 17'd4, 3'b001, 128'h104);
        drive_lane(1, 17'd5, 3'b011, 128'h105);
      end
      if (t >= 6)
        i_ready = 1'b1;
      step;
    end
  endtask

  task automatic test_overflow;
    clear_lanes;
    drive_lane(2, 17'd8, 3'b001, 128'h88);
    step;
    clear_lanes;
    n_cmp++;
    if (o_overflow !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_set: ovf=%b v=%b want 1 0", o_overflow, o_valid);
    end
    drive_lane(0, 17'd0, 3'b111, 128'h77);
    step;
    clear_lanes;
    step;
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 128'h77 || o_last !== 1'b1 ||
        o_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: v=%b d=%h l=%b ovf=%b want 1 77 1 1",
               o_valid, o_data, o_last, o_overflow);
    end
    step;
    n_cmp++;
    if (o_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_hold: got %b want 1", o_overflow);
    end
    pulse_reset;
  endtask

  task automatic test_collision;
    clear_lanes;
    drive_lane(0, 17'd2, 3'b001, 128'h21);
    drive_lane(3, 17'd2, 3'b001, 128'h22);
    step;
    clear_lanes;
    n_cmp++;
    if (o_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL collision: ovf=%b want 1", o_overflow);
    end
    pulse_reset;
  endtask

  task automatic test_single_block;
    clear_lanes;
    drive_lane(0, 17'd0, 3'b111, 128'h55);
    drive_lane(1, 17'h10000, 3'b100, 128'h66);
    step;
    clear_lanes;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_lat: v=%b want 0", o_valid);
    end
`ifdef AES_GCM_COLLECT_OCCUPANCY_EN
    n_cmp++;
    if (o_occupancy !== 4'd1) begin
      n_bad++;
      $display("FAIL single_occ1: got %0d want 1", o_occupancy);
    end
`endif
    step;
    n_cmp++;
    if (o_valid !== 1'b1 || o_counter !== 17'd0 || o_phase !== 3'b111 ||
        o_last !== 1'b1 || o_data !== 128'h55 || o_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL single_out: v=%b c=%h p=%b l=%b d=%h ovf=%b",
               o_valid, o_counter, o_phase, o_last, o_data, o_overflow);
    end
`ifdef AES_GCM_COLLECT_OCCUPANCY_EN
    n_cmp++;
    if (o_occupancy !== 4'd0) begin
      n_bad++;
      $display("FAIL single_occ0: got %0d want 0", o_occupancy);
    end
`endif
    step;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_once: v=%b want 0", o_valid);
    end
  endtask

  task automatic test_async_reset;
    i_ready = 1'b0;
    clear_lanes;
    drive_lane(0, 17'd0, 3'b000, 128'h40);
    drive_lane(1, 17'd1, 3'b001, 128'h41);
    drive_lane(2, 17'd2, 3'b001, 128'h42);
    drive_lane(3, 17'd3, 3'b001, 128'h43);
    step;
    clear_lanes;
    step;
    n_cmp++;
    if (o_valid !== 1'b1 || o_counter !== 17'd0) begin
      n_bad++;
      $display("FAIL arst_pre: v=%b c=%h want 1 0", o_valid, o_counter);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_phase !== 3'b100 || o_data !== 128'h0) begin
      n_bad++;
      $display("FAIL arst_now: v=%b p=%b d=%h want 0 100 0",
               o_valid, o_phase, o_data);
    end
    step;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    drive_lane(0, 17'd0, 3'b000, 128'h99);
    step;
    clear_lanes;
    step;
    n_cmp++;
    if (o_valid !== 1'b1 || o_counter !== 17'd0 || o_data !== 128'h99) begin
      n_bad++;
      $display("FAIL arst_after: v=%b c=%h d=%h want 1 0 99",
               o_valid, o_counter, o_data);
    end
    step;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_stale: v=%b c=%h want 0", o_valid, o_counter);
    end
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_valid   = '0;
    i_counter = '0;
    i_phase   = '0;
    i_data    = '0;
    i_ready   = 1'b1;
    step;
    step;
    test_reset;
    i_rst_n = 1'b1;
    step;
    test_in_order;
    test_out_of_order;
    test_backpressure;
    test_overflow;
    test_collision;
    test_single_block;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
